// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and the CDB entry type used by the requester ports and the
// broadcast register of the common data bus arbiter.
package cdb_arbiter_pkg;

  localparam int PHYSICAL_REG_NUM_WIDTH = 6;
  localparam int REG_VAL_WIDTH          = 32;
  localparam int ROB_SIZE_WIDTH         = 5;

  typedef struct packed {
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] register_addr;
    logic [REG_VAL_WIDTH-1:0]          register_val;
    logic [ROB_SIZE_WIDTH-1:0]         tag;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_priority_picker
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int REQ_IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [REQ_IDX_WIDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]       grant,
  output logic [REQ_IDX_WIDTH-1:0] grant_idx,
  output logic                     grant_valid
);

  logic [REQ_IDX_WIDTH-1:0] cand_idx_s;

  // Walk the requesters in priority order, latching the first valid one.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_idx_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_idx_s = REQ_IDX_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
      if (!grant_valid && req_valid[cand_idx_s]) begin
        grant[cand_idx_s] = 1'b1;
        grant_idx         = cand_idx_s;
        grant_valid       = 1'b1;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one combinational grant per
// cycle, winner's result broadcast from a register on the following cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int REQ_IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            flush,
  input  logic [NUM_REQ-1:0]                              req_valid,
  input  logic [NUM_REQ-1:0][PHYSICAL_REG_NUM_WIDTH-1:0]  req_reg_addr,
  input  logic [NUM_REQ-1:0][REG_VAL_WIDTH-1:0]           req_reg_val,
  input  logic [NUM_REQ-1:0][ROB_SIZE_WIDTH-1:0]          req_tag,
  output logic [NUM_REQ-1:0]                              req_ready,
  output logic                                            cdb_valid,
  output logic [PHYSICAL_REG_NUM_WIDTH-1:0]               cdb_register_addr,
  output logic [REG_VAL_WIDTH-1:0]                        cdb_register_val,
  output logic [ROB_SIZE_WIDTH-1:0]                       cdb_tag,
  output logic [REQ_IDX_WIDTH-1:0]                        cdb_src_idx
);

  logic [REQ_IDX_WIDTH-1:0] rr_ptr_r;
  logic                     cdb_valid_r;
  cdb_entry_t               cdb_entry_r;
  logic [REQ_IDX_WIDTH-1:0] cdb_src_idx_r;

  logic [NUM_REQ-1:0]       grant_s;
  logic [REQ_IDX_WIDTH-1:0] grant_idx_s;
  logic                     grant_valid_s;
  logic                     grant_en_s;
  logic [REQ_IDX_WIDTH-1:0] next_ptr_s;
  cdb_entry_t               req_entry_s [NUM_REQ];

  rr_priority_picker #(
    .NUM_REQ       (NUM_REQ),
    .REQ_IDX_WIDTH (REQ_IDX_WIDTH)
  ) u_picker (
    .req_valid   (req_valid),
    .rr_ptr      (rr_ptr_r),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // Pack the per-requester result fields into CDB entries.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_entry_s[i].register_addr = req_reg_addr[i];
      req_entry_s[i].register_val  = req_reg_val[i];
      req_entry_s[i].tag           = req_tag[i];
    end
  end

  // Flush and reset both veto the grant; the pointer advances past the winner.
  always_comb begin
    grant_en_s = grant_valid_s & ~flush & ~reset;
    if (grant_en_s) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
    if (grant_idx_s == REQ_IDX_WIDTH'(NUM_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_idx_s + REQ_IDX_WIDTH'(1);
    end
  end

  // Pointer and broadcast register; data fields hold when nothing is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_r      <= '0;
      cdb_valid_r   <= 1'b0;
      cdb_entry_r   <= '0;
      cdb_src_idx_r <= '0;
    end else if (grant_en_s) begin
      rr_ptr_r      <= next_ptr_s;
      cdb_valid_r   <= 1'b1;
      cdb_entry_r   <= req_entry_s[grant_idx_s];
      cdb_src_idx_r <= grant_idx_s;
    end else begin
      cdb_valid_r   <= 1'b0;
    end
  end

  assign cdb_valid         = cdb_valid_r;
  assign cdb_register_addr = cdb_entry_r.register_addr;
  assign cdb_register_val  = cdb_entry_r.register_val;
  assign cdb_tag           = cdb_entry_r.tag;
  assign cdb_src_idx       = cdb_src_idx_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic
// compared against a priority-list reference model of the round-robin bus.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int IW      = $clog2(NUM_REQ);

  logic                                           clk = 1'b0;
  logic                                           reset;
  logic                                           flush;
  logic [NUM_REQ-1:0]                             req_valid;
  logic [NUM_REQ-1:0][PHYSICAL_REG_NUM_WIDTH-1:0] req_reg_addr;
  logic [NUM_REQ-1:0][REG_VAL_WIDTH-1:0]          req_reg_val;
  logic [NUM_REQ-1:0][ROB_SIZE_WIDTH-1:0]         req_tag;
  logic [NUM_REQ-1:0]                             req_ready;
  logic                                           cdb_valid;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0]              cdb_register_addr;
  logic [REG_VAL_WIDTH-1:0]                       cdb_register_val;
  logic [ROB_SIZE_WIDTH-1:0]                      cdb_tag;
  logic [IW-1:0]                                  cdb_src_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // Requester side: each unit holds one result until it is acknowledged.
  bit                                pend   [NUM_REQ];
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] p_addr [NUM_REQ];
  logic [REG_VAL_WIDTH-1:0]          p_val  [NUM_REQ];
  logic [ROB_SIZE_WIDTH-1:0]         p_tag  [NUM_REQ];
  int                                wait_c [NUM_REQ];

  // Reference model: priority order list plus expected broadcast.
  int                                order[$];
  bit                                m_valid;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] m_addr;
  logic [REG_VAL_WIDTH-1:0]          m_val;
  logic [ROB_SIZE_WIDTH-1:0]         m_tag;
  int                                m_src;

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .REQ_IDX_WIDTH(IW)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .req_valid         (req_valid),
    .req_reg_addr      (req_reg_addr),
    .req_reg_val       (req_reg_val),
    .req_tag           (req_tag),
    .req_ready         (req_ready),
    .cdb_valid         (cdb_valid),
    .cdb_register_addr (cdb_register_addr),
    .cdb_register_val  (cdb_register_val),
    .cdb_tag           (cdb_tag),
    .cdb_src_idx       (cdb_src_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    order.delete();
    for (int k = 0; k < NUM_REQ; k++) order.push_back(k);
    m_valid = 1'b0;
    m_addr  = '0;
    m_val   = '0;
    m_tag   = '0;
    m_src   = 0;
  endtask

  function automatic int model_pick(input bit fl);
    if (fl) return -1;
    foreach (order[k]) if (pend[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic model_grant(input int g);
    m_valid = 1'b1;
    m_addr  = p_addr[g];
    m_val   = p_val[g];
    m_tag   = p_tag[g];
    m_src   = g;
    order.delete();
    for (int k = 1; k <= NUM_REQ; k++) order.push_back((g + k) % NUM_REQ);
    chk("fairness_wait_within_n", 64'(wait_c[g] <= NUM_REQ), 64'd1);
    pend[g] = 1'b0;
  endtask

  task automatic post(input int i, input logic [31:0] a, input logic [31:0] v, input logic [31:0] t);
    if (!pend[i]) begin
      pend[i]   = 1'b1;
      p_addr[i] = PHYSICAL_REG_NUM_WIDTH'(a);
      p_val[i]  = v;
      p_tag[i]  = ROB_SIZE_WIDTH'(t);
      wait_c[i] = 0;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]    = pend[i];
      req_reg_addr[i] = p_addr[i];
      req_reg_val[i]  = p_val[i];
      req_tag[i]      = p_tag[i];
    end
  endtask

  task automatic check_outputs();
    chk("cdb_valid", cdb_valid, m_valid);
    chk("cdb_register_addr", cdb_register_addr, m_addr);
    chk("cdb_register_val", cdb_register_val, m_val);
    chk("cdb_tag", cdb_tag, m_tag);
    chk("cdb_src_idx", cdb_src_idx, m_src);
  endtask

  // One arbitration cycle: check outputs, drive, check grant, step the model.
  task automatic cycle(input bit fl);
    int g;
    logic [NUM_REQ-1:0] exp_ready;
    @(negedge clk);
    check_outputs();
    flush = fl;
    drive_inputs();
    #1;
    g = model_pick(fl);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    for (int i = 0; i < NUM_REQ; i++) if (pend[i] && !fl) wait_c[i]++;
    @(posedge clk);
    if (g >= 0) model_grant(g);
    else m_valid = 1'b0;
    #1;
    drive_inputs();
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b0; p_addr[i] = '0; p_val[i] = '0; p_tag[i] = '0; wait_c[i] = 0;
    end
    drive_inputs();
    req_valid = '1;
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    check_outputs();
    chk("reset_req_ready", req_ready, 3'b000);
    req_valid = '0;
    reset = 1'b0;

    // Single request at index 1.
    post(1, 32'd5, 32'hDEAD_BEEF, 32'd2);
    cycle(1'b0);
    #2;
    chk("single_valid", cdb_valid, 1'b1);
    chk("single_addr", cdb_register_addr, 6'd5);
    chk("single_val", cdb_register_val, 32'hDEAD_BEEF);
    chk("single_tag", cdb_tag, 5'd2);
    chk("single_src", cdb_src_idx, 2'd1);

    // All three held valid: back-to-back grants in rotating order.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NUM_REQ; i++) post(i, $urandom, $urandom, $urandom);
      cycle(1'b0);
    end
    cycle(1'b0);
    cycle(1'b0);

    // Wrap: pointer at 2 with requesters 0 and 1 valid picks 0.
    post(1, 32'd7, 32'h1111_2222, 32'd3);
    cycle(1'b0);
    post(0, 32'd8, 32'h3333_4444, 32'd4);
    post(1, 32'd9, 32'h5555_6666, 32'd5);
    cycle(1'b0);
    #2;
    chk("wrap_src", cdb_src_idx, 2'd0);
    cycle(1'b0);
    cycle(1'b0);

    // Flush with every requester valid, then resume.
    for (int i = 0; i < NUM_REQ; i++) post(i, $urandom, $urandom, $urandom);
    cycle(1'b1);
    cycle(1'b1);
    repeat (4) cycle(1'b0);

    // Idle stretch: outputs must drop valid and hold data.
    repeat (5) cycle(1'b0);

    // Async reset during a broadcast with index 2 still waiting.
    post(2, 32'd11, 32'hAAAA_0002, 32'd6);
    cycle(1'b0);
    post(0, 32'd12, 32'hBBBB_0000, 32'd7);
    post(2, 32'd13, 32'hCCCC_0002, 32'd8);
    cycle(1'b0);
    #1;
    reset = 1'b1;
    req_valid = '0;
    #1;
    chk("arst_valid", cdb_valid, 1'b0);
    chk("arst_addr", cdb_register_addr, 6'd0);
    chk("arst_val", cdb_register_val, 32'd0);
    chk("arst_tag", cdb_tag, 5'd0);
    chk("arst_src", cdb_src_idx, 2'd0);
    chk("arst_req_ready", req_ready, 3'b000);
    model_reset();
    wait_c[2] = 0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < NUM_REQ && pend[2]; k++) cycle(1'b0);
    chk("arst_regrant_within_n", pend[2], 1'b0);

    // Random traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if ($urandom_range(99) < 45) post(i, $urandom, $urandom, $urandom);
      cycle($urandom_range(9) == 0);
    end
    repeat (NUM_REQ + 2) cycle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) among the execution units (ALU, memory, branch) that produce register results. Each cycle it selects at most one requester by round-robin, acknowledges it with a ready handshake, and broadcasts the winner's result one cycle later on registered CDB outputs. Those outputs drive the physical register file write port (`dst_wr_en`/`dst_phy_reg`/`dst_val`), the reservation-station wakeup logic and the ROB completion logic. Registered CDB outputs keep the broadcast glitch-free and aligned to a clock edge for every consumer.

## Interface
Parameters:
- NUM_REQ, 3: number of requesting execution units; minimum 2.
- REQ_IDX_WIDTH, $clog2(NUM_REQ): width of the requester index.

Ports:
- clk  in  1  system clock; one clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush. No grant while high; clears the pending CDB broadcast.
- req_valid  in  NUM_REQ  per-requester result valid.
- req_reg_addr  in  NUM_REQ x `PHYSICAL_REG_NUM_WIDTH`  destination physical register.
- req_reg_val  in  NUM_REQ x `REG_VAL_WIDTH`  result value.
- req_tag  in  NUM_REQ x `ROB_SIZE_WIDTH`  ROB tag of the producing instruction.
- req_ready  out  NUM_REQ  combinational grant; a transfer occurs when valid & ready.
- cdb_valid  out  1  registered broadcast valid.
- cdb_register_addr  out  `PHYSICAL_REG_NUM_WIDTH`  registered broadcast register.
- cdb_register_val  out  `REG_VAL_WIDTH`  registered broadcast value.
- cdb_tag  out  `ROB_SIZE_WIDTH`  registered broadcast ROB tag.
- cdb_src_idx  out  REQ_IDX_WIDTH  index of the requester being broadcast (debug/perf).

## Operation
- State: round-robin pointer `rr_ptr` (REQ_IDX_WIDTH bits) plus the CDB output register.
- Selection:
  - Search `req_valid` starting at `rr_ptr`, ascending, wrapping from NUM_REQ-1 to 0.
  - The first valid requester wins.
  - At most one bit of `req_ready` is high.
  - `req_ready` is all-zero when `flush` is high or no request is valid.
- On a grant to index g:
  - The output register loads `cdb_valid`=1 together with `req_reg_addr[g]`, `req_reg_val[g]`, `req_tag[g]` and `cdb_src_idx`=g.
  - `rr_ptr` <= (g==NUM_REQ-1) ? 0 : g+1.
- No grant: `cdb_valid` <= 0, data fields hold their previous values, `rr_ptr` holds.
- Flush: `cdb_valid` <= 0 at the next edge, `rr_ptr` holds, requests are not acknowledged. A broadcast already showing on the outputs during the flush cycle completes normally.
- Requester rule: `req_valid` and its data stay stable until acknowledged. The arbiter never drops an acknowledged result.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles of raising valid, provided flush stays low.

## Timing
- Reset values:
  - `cdb_valid`=0, `cdb_register_addr`=0, `cdb_register_val`=0, `cdb_tag`=0, `cdb_src_idx`=0.
  - `rr_ptr`=0; `req_ready`=0 while reset is high.
- Latency: request valid at edge N with grant → broadcast visible from edge N+1 for exactly one cycle.
- Throughput: one broadcast per cycle with back-to-back grants; no bubble between consecutive broadcasts.
- Register-file write at edge N+2, so the value can be read from N+2 onward. Same-cycle forwarding is the reservation stations' job, using `cdb_valid`/`cdb_tag`.
- Simultaneous flush and valid requests: flush wins; nothing is granted.
- Reset asserted mid-broadcast: outputs clear immediately (asynchronously); any unacknowledged request is re-arbitrated after reset from `rr_ptr`=0.

## Structure
- Shared package/defines:
  - `PHYSICAL_REG_NUM_WIDTH`, `REG_VAL_WIDTH`, `ROB_SIZE_WIDTH`.
  - Typedef `cdb_entry_t` {register_addr, register_val, tag}, used for the per-requester inputs and the output register.
- Sub-module `rr_priority_picker` (combinational; inputs `req_valid` and `rr_ptr`; outputs a one-hot grant and the grant index). This module instantiates it and owns the pointer and output registers.
- The top level binds the `cdb_*` outputs onto `CDB_IF` (valid, register_addr, register_val).

## Test plan
- Reset then single request (NUM_REQ=3): req_valid=3'b010, addr=5, val=32'hDEAD_BEEF, tag=2 → req_ready=3'b010 same cycle; next cycle cdb_valid=1, addr=5, val=DEADBEEF, tag=2, src_idx=1; rr_ptr=2.
- All three valid and held: grants in order 0,1,2,0 on consecutive cycles; cdb_valid high four consecutive cycles; src_idx 0,1,2,0.
- Wrap: rr_ptr=2, req_valid=3'b011 → grant index 0 (not 1); rr_ptr becomes 1.
- Flush with req_valid=3'b111 → req_ready=0; cdb_valid=0 next cycle; rr_ptr unchanged; after flush drops, grant resumes at the old rr_ptr.
- Async reset asserted mid-cycle while cdb_valid=1 → all outputs 0 before the next edge; after release, the held request at index 2 is granted within 3 cycles.
- Idle: req_valid=0 for 5 cycles → cdb_valid=0 throughout; data outputs and rr_ptr unchanged.
